// File: rtl/fetch_prefetch_stage_if.sv
// Port bundle of fetch_prefetch_stage: program load, pipeline control and decode-side outputs.
// FETCH_PERF_COUNTERS_EN adds the bubble/flush counter outputs.
interface fetch_prefetch_stage_if #(
    parameter int unsigned NB_DATA     = 32,
    parameter int unsigned NB_REGISTER = 5,
    parameter int unsigned NB_ADDRESS  = 8,
    parameter int unsigned NB_FIFO_PTR = 2
);
    logic                   i_valid;
    logic                   i_prog_write_enable;
    logic [NB_ADDRESS-1:0]  i_prog_write_address;
    logic [NB_DATA-1:0]     i_prog_write_data;
    logic                   i_pc_src;
    logic [NB_DATA-1:0]     i_pc_next;
    logic                   i_stall;
    logic                   i_execution_mode;
    logic                   i_step;
    logic [NB_DATA-1:0]     o_instruction;
    logic [NB_DATA-1:0]     o_pc_next;
    logic [NB_REGISTER-1:0] o_rs;
    logic [NB_REGISTER-1:0] o_rt;
    logic                   o_valid;
    logic                   o_halt;
    logic [NB_FIFO_PTR:0]   o_fifo_count;
`ifdef FETCH_PERF_COUNTERS_EN
    logic [31:0]            o_bubble_count;
    logic [31:0]            o_flush_count;
`endif

    modport slave (
        input  i_valid, i_prog_write_enable, i_prog_write_address, i_prog_write_data,
        input  i_pc_src, i_pc_next, i_stall, i_execution_mode, i_step,
`ifdef FETCH_PERF_COUNTERS_EN
        output o_bubble_count, o_flush_count,
`endif
        output o_instruction, o_pc_next, o_rs, o_rt, o_valid, o_halt, o_fifo_count
    );

    modport master (
        output i_valid, i_prog_write_enable, i_prog_write_address, i_prog_write_data,
        output i_pc_src, i_pc_next, i_stall, i_execution_mode, i_step,
`ifdef FETCH_PERF_COUNTERS_EN
        input  o_bubble_count, o_flush_count,
`endif
        input  o_instruction, o_pc_next, o_rs, o_rt, o_valid, o_halt, o_fifo_count
    );
endinterface

// File: rtl/fetch_prefetch_stage.sv
// Instruction fetch with loadable memory and prefetch FIFO; redirect, stall, step, halt.
// Optional FETCH_PERF_COUNTERS_EN adds saturating bubble/flush counters.
module fetch_prefetch_stage #(
    parameter int unsigned NB_DATA     = 32,
    parameter int unsigned NB_REGISTER = 5,
    parameter int unsigned NB_ADDRESS  = 8,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned NB_FIFO_PTR = 2,
    parameter logic [5:0]  HALT_OPCODE = 6'b111111
) (
    input logic                   i_clock,
    input logic                   i_reset,
    fetch_prefetch_stage_if.slave bus
);
    localparam int unsigned          MEM_DEPTH = 2 ** NB_ADDRESS;
    localparam logic [NB_FIFO_PTR:0] FIFO_FULL = (NB_FIFO_PTR + 1)'(FIFO_DEPTH);

    logic [NB_DATA-1:0]     r_mem [MEM_DEPTH];
    logic [NB_DATA-1:0]     r_fifo_instr [FIFO_DEPTH];
    logic [NB_DATA-1:0]     r_fifo_pc [FIFO_DEPTH];
    logic [NB_DATA-1:0]     r_fetch_pc, r_mem_data, r_inflight_pc;
    logic                   r_inflight, r_halt_seen;
    logic [NB_FIFO_PTR-1:0] r_wr_ptr, r_rd_ptr;
    logic [NB_FIFO_PTR:0]   r_count;
    logic [NB_DATA-1:0]     r_instruction, r_pc_next;
    logic                   r_valid, r_halt;

    logic                   w_redirect, w_advance, w_out_en, w_empty;
    logic                   w_pop, w_push, w_push_halt, w_issue;
    logic [NB_FIFO_PTR:0]   w_occupancy;
    logic [NB_DATA-1:0]     w_head_instr, w_head_pc;

    assign w_redirect   = bus.i_valid & bus.i_pc_src;
    assign w_advance    = ~bus.i_execution_mode | bus.i_step;
    // Once a halt reaches the outputs they freeze there until reset.
    assign w_out_en     = bus.i_valid & ~bus.i_stall & w_advance & ~r_halt;
    assign w_empty      = (r_count == '0);
    assign w_pop        = w_out_en & ~w_redirect & ~w_empty;
    assign w_push       = bus.i_valid & ~w_redirect & r_inflight;
    assign w_push_halt  = w_push & (r_mem_data[NB_DATA-1 -: 6] == HALT_OPCODE);
    assign w_occupancy  = r_count + (NB_FIFO_PTR + 1)'(r_inflight) - (NB_FIFO_PTR + 1)'(w_pop);
    // Nothing past a halt word is fetched, so no further pushes follow it.
    assign w_issue      = bus.i_valid & ~w_redirect & ~r_halt_seen & ~w_push_halt
                        & (w_occupancy < FIFO_FULL);
    assign w_head_instr = r_fifo_instr[r_rd_ptr];
    assign w_head_pc    = r_fifo_pc[r_rd_ptr];

    always_ff @(posedge i_clock) begin
        if (bus.i_prog_write_enable && !bus.i_valid) begin
            r_mem[bus.i_prog_write_address] <= bus.i_prog_write_data;
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_fetch_pc    <= '0;
            r_mem_data    <= '0;
            r_inflight_pc <= '0;
            r_inflight    <= 1'b0;
            r_halt_seen   <= 1'b0;
        end else if (w_redirect) begin
            r_fetch_pc  <= bus.i_pc_next;
            r_inflight  <= 1'b0;
            r_halt_seen <= 1'b0;
        end else if (bus.i_valid) begin
            r_inflight <= w_issue;
            if (w_push_halt) begin
                r_halt_seen <= 1'b1;
            end
            if (w_issue) begin
                r_mem_data    <= r_mem[r_fetch_pc[NB_ADDRESS-1:0]];
                r_inflight_pc <= r_fetch_pc;
                r_fetch_pc    <= r_fetch_pc + NB_DATA'(1);
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (w_push) begin
            r_fifo_instr[r_wr_ptr] <= r_mem_data;
            r_fifo_pc[r_wr_ptr]    <= r_inflight_pc;
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (w_redirect) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + NB_FIFO_PTR'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + NB_FIFO_PTR'(1);
            r_count <= r_count + (NB_FIFO_PTR + 1)'(w_push) - (NB_FIFO_PTR + 1)'(w_pop);
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_instruction <= '0;
            r_pc_next     <= '0;
            r_valid       <= 1'b0;
            r_halt        <= 1'b0;
        end else if (w_redirect && !r_halt) begin
            r_instruction <= '0;
            r_valid       <= 1'b0;
        end else if (w_out_en) begin
            if (!w_empty) begin
                r_instruction <= w_head_instr;
                r_pc_next     <= w_head_pc + NB_DATA'(1);
                r_valid       <= 1'b1;
                r_halt        <= (w_head_instr[NB_DATA-1 -: 6] == HALT_OPCODE);
            end else begin
                r_instruction <= '0;
                r_valid       <= 1'b0;
            end
        end
    end

    assign bus.o_instruction = r_instruction;
    assign bus.o_pc_next     = r_pc_next;
    assign bus.o_rs          = r_instruction[25:21];
    assign bus.o_rt          = r_instruction[20:16];
    assign bus.o_valid       = r_valid;
    assign bus.o_halt        = r_halt;
    assign bus.o_fifo_count  = r_count;

`ifdef FETCH_PERF_COUNTERS_EN
    logic [31:0] r_bubble_count, r_flush_count;
    logic        w_bubble_evt;

    assign w_bubble_evt = w_out_en & (w_redirect | w_empty);

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_bubble_count <= '0;
            r_flush_count  <= '0;
        end else begin
            if (w_bubble_evt && (r_bubble_count != '1)) r_bubble_count <= r_bubble_count + 32'd1;
            if (w_redirect && (r_flush_count != '1))    r_flush_count  <= r_flush_count + 32'd1;
        end
    end

    assign bus.o_bubble_count = r_bubble_count;
    assign bus.o_flush_count  = r_flush_count;
`endif
endmodule

// File: tb/tb_fetch_prefetch_stage.sv
// Self-checking bench for fetch_prefetch_stage: queue-based reference model, directed and
// randomized stimulus.
module tb_fetch_prefetch_stage;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fetch_prefetch_stage_if #(.NB_DATA(32), .NB_REGISTER(5), .NB_ADDRESS(8), .NB_FIFO_PTR(2)) bus();

    fetch_prefetch_stage #(
        .NB_DATA(32), .NB_REGISTER(5), .NB_ADDRESS(8), .FIFO_DEPTH(4), .NB_FIFO_PTR(2),
        .HALT_OPCODE(6'b111111)
    ) dut (
        .i_clock(clk),
        .i_reset(rst),
        .bus(bus)
    );

    // Reference model: memory image, fetch PC, one outstanding read, FIFO as queues.
    logic [31:0] m_mem [256];
    logic [31:0] img [256];
    logic [31:0] m_fpc, m_infl_pc, m_infl_word;
    bit          m_infl, m_halt_seen;
    logic [31:0] q_pc[$];
    logic [31:0] q_word[$];
    logic [31:0] m_instr, m_pcn;
    bit          m_valid, m_halt;
    logic [31:0] m_bub, m_flush;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit chk_en = 0;
    bit mode_r;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        m_fpc = 0; m_infl = 0; m_halt_seen = 0;
        q_pc.delete(); q_word.delete();
        m_instr = 0; m_pcn = 0; m_valid = 0; m_halt = 0;
        m_bub = 0; m_flush = 0;
    endtask

    function automatic bit is_halt(input logic [31:0] w);
        return w[31:26] == 6'h3f;
    endfunction

    task automatic model_step();
        bit adv, out_en, halt_now, issue;
        int occ;
        if (!bus.i_valid) begin
            if (bus.i_prog_write_enable) m_mem[bus.i_prog_write_address] = bus.i_prog_write_data;
            return;
        end
        adv    = !bus.i_execution_mode || bus.i_step;
        out_en = !bus.i_stall && adv && !m_halt;
        if (bus.i_pc_src) begin
            q_pc.delete(); q_word.delete();
            m_infl = 0; m_fpc = bus.i_pc_next; m_halt_seen = 0;
            m_flush++;
            if (!m_halt) begin m_instr = 0; m_valid = 0; end
            if (out_en) m_bub++;
            return;
        end
        if (out_en) begin
            if (q_pc.size() > 0) begin
                m_pcn   = q_pc.pop_front() + 1;
                m_instr = q_word.pop_front();
                m_valid = 1;
                m_halt  = is_halt(m_instr);
            end else begin
                m_instr = 0; m_valid = 0; m_bub++;
            end
        end
        halt_now = m_infl && is_halt(m_infl_word);
        occ      = q_pc.size() + int'(m_infl);
        issue    = !m_halt_seen && !halt_now && occ < 4;
        if (m_infl) begin
            q_pc.push_back(m_infl_pc);
            q_word.push_back(m_infl_word);
            if (halt_now) m_halt_seen = 1;
        end
        m_infl = issue;
        if (issue) begin
            m_infl_pc   = m_fpc;
            m_infl_word = m_mem[m_fpc[7:0]];
            m_fpc++;
        end
    endtask

    task automatic compare_all();
        logic [31:0] w;
        w = m_instr;
        check("instruction", bus.o_instruction, m_instr);
        check("pc_next", bus.o_pc_next, m_pcn);
        check("rs", 32'(bus.o_rs), 32'(w[25:21]));
        check("rt", 32'(bus.o_rt), 32'(w[20:16]));
        check("valid", 32'(bus.o_valid), 32'(m_valid));
        check("halt", 32'(bus.o_halt), 32'(m_halt));
        check("fifo_count", 32'(bus.o_fifo_count), 32'(q_pc.size()));
`ifdef FETCH_PERF_COUNTERS_EN
        check("bubble_count", bus.o_bubble_count, m_bub);
        check("flush_count", bus.o_flush_count, m_flush);
`endif
    endtask

    always @(negedge clk) if (chk_en) compare_all();

    task automatic tick();
        @(posedge clk);
        if (!rst) model_step();
        #1;
        cyc++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        tick();
        rst = 1'b0;
    endtask

    task automatic prog_write(input logic [7:0] a, input logic [31:0] d);
        bus.i_valid = 0;
        bus.i_prog_write_enable = 1;
        bus.i_prog_write_address = a;
        bus.i_prog_write_data = d;
        tick();
        bus.i_prog_write_enable = 0;
    endtask

    initial begin
        logic [31:0] w;
        rst = 1'b1;
        bus.i_valid = 0; bus.i_prog_write_enable = 0; bus.i_prog_write_address = 0;
        bus.i_prog_write_data = 0; bus.i_pc_src = 0; bus.i_pc_next = 0; bus.i_stall = 0;
        bus.i_execution_mode = 0; bus.i_step = 0;
        model_reset();
        ticks(2);
        chk_en = 1;
        check("reset_valid", 32'(bus.o_valid), 32'd0);
        check("reset_pc_next", bus.o_pc_next, 32'd0);
        rst = 1'b0;

        // Program image: 0..7 = 0x2001000n, word 8 halts, the rest random non-halt words.
        for (int i = 0; i < 256; i++) begin
            w = $urandom;
            if (w[31:26] == 6'h3f) w[31] = 1'b0;
            if (i < 8) w = 32'h2001_0000 | 32'(i);
            if (i == 8) w = 32'hfc00_0000;
            img[i] = w;
            prog_write(8'(i), w);
        end

        // Cold start to halt.
        bus.i_valid = 1;
        ticks(3);
        check("first_valid", 32'(bus.o_valid), 32'd1);
        check("first_pc_next", bus.o_pc_next, 32'd1);
        check("first_instr", bus.o_instruction, 32'h2001_0000);
        ticks(8);
        check("halt_pc_next", bus.o_pc_next, 32'd9);
        check("halt_flag", 32'(bus.o_halt), 32'd1);
        check("halt_instr", bus.o_instruction, 32'hfc00_0000);
        ticks(4);
        check("halt_no_push", 32'(bus.o_fifo_count), 32'd0);
        check("halt_hold_pc", bus.o_pc_next, 32'd9);

        // Stall saturates the FIFO, then redirect with 3 entries queued.
        do_reset();
        img[8] = 32'h2001_0008;
        prog_write(8'd8, img[8]);
        bus.i_valid = 1;
        ticks(6);
        bus.i_stall = 1;
        ticks(6);
        check("stall_full", 32'(bus.o_fifo_count), 32'd4);
        bus.i_stall = 0;
        ticks(10);
        check("pre_redirect_count", 32'(bus.o_fifo_count), 32'd3);
        bus.i_pc_src = 1; bus.i_pc_next = 32'h20;
        tick();
        bus.i_pc_src = 0;
        check("redirect_flush", 32'(bus.o_fifo_count), 32'd0);
        check("redirect_bubble", 32'(bus.o_valid), 32'd0);
        ticks(3);
        check("redirect_target_pc", bus.o_pc_next, 32'h21);
        check("redirect_target_instr", bus.o_instruction, img[32'h20]);

        // Step mode: three pulses five cycles apart.
        do_reset();
        bus.i_execution_mode = 1;
        bus.i_valid = 1;
        for (int p = 0; p < 3; p++) begin
            ticks(4);
            bus.i_step = 1;
            tick();
            bus.i_step = 0;
            check("step_pc_next", bus.o_pc_next, 32'(p + 1));
        end
        ticks(4);
        check("step_hold", bus.o_pc_next, 32'd3);
        bus.i_execution_mode = 0;

        // Asynchronous reset between edges, then restart from address 0.
        ticks(5);
        @(posedge clk);
        model_step();
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check("async_rst_valid", 32'(bus.o_valid), 32'd0);
        check("async_rst_pc", bus.o_pc_next, 32'd0);
        check("async_rst_count", 32'(bus.o_fifo_count), 32'd0);
        tick();
        rst = 1'b0;
        ticks(3);
        check("restart_pc", bus.o_pc_next, 32'd1);
        check("restart_instr", bus.o_instruction, img[0]);

        // Randomized traffic.
        mode_r = 0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 99) < 2) begin
                do_reset();
                continue;
            end
            if ($urandom_range(0, 49) == 0) mode_r = !mode_r;
            bus.i_execution_mode = mode_r;
            bus.i_valid = ($urandom_range(0, 9) != 0);
            bus.i_stall = ($urandom_range(0, 4) == 0);
            bus.i_step  = ($urandom_range(0, 2) == 0);
            bus.i_pc_src = ($urandom_range(0, 19) == 0);
            bus.i_pc_next = ($urandom_range(0, 7) == 0) ? (32'hffff_fffc + 32'($urandom_range(0, 3)))
                                                        : 32'($urandom_range(0, 255));
            bus.i_prog_write_enable = $urandom_range(0, 1);
            bus.i_prog_write_address = 8'($urandom_range(0, 255));
            w = $urandom;
            if ($urandom_range(0, 15) != 0 && w[31:26] == 6'h3f) w[31] = 1'b0;
            if ($urandom_range(0, 15) == 0) w[31:26] = 6'h3f;
            bus.i_prog_write_data = w;
            tick();
        end
        bus.i_valid = 0; bus.i_pc_src = 0; bus.i_prog_write_enable = 0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
